// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: base opcodes and the immediate formats used by decode.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: scatters the RV32I immediate fields back into a
// sign-extended word according to the decoded format.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register-file addressing, write-back bypass, immediate
// generation and a single ID/EX register with valid/ready flow control.
module id_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    input  logic [XLEN-1:0] rf_op_a,
    input  logic [XLEN-1:0] rf_op_b,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_op_a,
    output logic [XLEN-1:0] out_op_b,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic            out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            rd_we;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic            illegal;
    } idex_t;

    idex_t    idex_q, idex_d;
    logic     valid_q, valid_d;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic        legal;
    logic        writes_rd;
    logic        illegal;
    imm_fmt_e    fmt;
    logic [31:0] imm;
    logic        accept;
    logic        hold;
    logic [XLEN-1:0] op_a_byp;
    logic [XLEN-1:0] op_b_byp;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign rf_rs1 = in_instr[19:15];
    assign rf_rs2 = in_instr[24:20];

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign hold     = valid_q && !out_ready;

    always_comb begin
        legal     = 1'b1;
        writes_rd = 1'b0;
        fmt       = IMM_NONE;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                fmt       = IMM_U;
                writes_rd = 1'b1;
            end
            OPC_JAL: begin
                fmt       = IMM_J;
                writes_rd = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                fmt       = IMM_I;
                writes_rd = 1'b1;
            end
            OPC_FENCE, OPC_SYSTEM: fmt = IMM_I;
            OPC_STORE:             fmt = IMM_S;
            OPC_BRANCH:            fmt = IMM_B;
            OPC_OP:                writes_rd = 1'b1;
            default:               legal = 1'b0;
        endcase
    end

    // Every legal opcode already ends in 2'b11; the explicit test documents the rule.
    assign illegal = !legal || (in_instr[1:0] != 2'b11);

    imm_gen u_imm_gen (
        .instr (in_instr[31:7]),
        .fmt   (illegal ? IMM_NONE : fmt),
        .imm   (imm)
    );

    // The register file returns the pre-write value on a same-cycle write.
    assign op_a_byp = (wb_en && wb_rd == rf_rs1 && rf_rs1 != 5'd0) ? wb_data : rf_op_a;
    assign op_b_byp = (wb_en && wb_rd == rf_rs2 && rf_rs2 != 5'd0) ? wb_data : rf_op_b;

    always_comb begin
        idex_d = idex_q;
        if (accept) begin
            idex_d.pc       = in_pc;
            idex_d.op_a     = op_a_byp;
            idex_d.op_b     = op_b_byp;
            idex_d.rs1      = rf_rs1;
            idex_d.rs2      = rf_rs2;
            idex_d.imm      = imm;
            idex_d.rd       = rd;
            idex_d.rd_we    = writes_rd && !illegal && (rd != 5'd0);
            idex_d.opcode   = opcode;
            idex_d.funct3   = in_instr[14:12];
            idex_d.funct7b5 = in_instr[30];
            idex_d.illegal  = illegal;
        end else if (hold) begin
            // Stalled operands track later write-backs so they are not stale at transfer.
            if (wb_en && wb_rd == idex_q.rs1 && idex_q.rs1 != 5'd0) idex_d.op_a = wb_data;
            if (wb_en && wb_rd == idex_q.rs2 && idex_q.rs2 != 5'd0) idex_d.op_b = wb_data;
        end

        if (flush)       valid_d = 1'b0;
        else if (accept) valid_d = 1'b1;
        else             valid_d = hold;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            idex_q  <= '0;
        end else begin
            valid_q <= valid_d;
            idex_q  <= idex_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = idex_q.pc;
    assign out_op_a     = idex_q.op_a;
    assign out_op_b     = idex_q.op_b;
    assign out_rs1      = idex_q.rs1;
    assign out_rs2      = idex_q.rs2;
    assign out_imm      = idex_q.imm;
    assign out_rd       = idex_q.rd;
    assign out_rd_we    = idex_q.rd_we;
    assign out_opcode   = idex_q.opcode;
    assign out_funct3   = idex_q.funct3;
    assign out_funct7b5 = idex_q.funct7b5;
    assign out_illegal  = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized traffic checked
// against a behavioural model of the decode stage.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, wb_en;
    logic [31:0] in_instr, in_pc, rf_op_a, rf_op_b, wb_data;
    logic [4:0]  wb_rd;
    logic        in_ready, out_valid, out_rd_we, out_funct7b5, out_illegal;
    logic [4:0]  rf_rs1, rf_rs2, out_rs1, out_rs2, out_rd;
    logic [31:0] out_pc, out_op_a, out_op_b, out_imm;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;

    always #5 clk = ~clk;

    id_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_op_a(rf_op_a), .rf_op_b(rf_op_b),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_op_a(out_op_a), .out_op_b(out_op_b), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_rd(out_rd), .out_rd_we(out_rd_we), .out_opcode(out_opcode),
        .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_illegal(out_illegal)
    );

    localparam logic [31:0] ADDI = 32'hFFF08293;
    localparam logic [31:0] SW   = 32'h0021A423;
    localparam logic [31:0] JAL  = 32'hFFDFF0EF;

    int total = 0;
    int bad   = 0;

    // Reference state of the ID/EX register.
    bit          m_valid;
    logic [31:0] m_pc, m_a, m_b, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [6:0]  m_opc;
    logic [2:0]  m_f3;
    logic        m_we, m_f7, m_ill;

    wire [155:0] dut_vec = {out_pc, out_op_a, out_op_b, out_rs1, out_rs2, out_imm,
                            out_rd, out_rd_we, out_opcode, out_funct3, out_funct7b5, out_illegal};
    wire [155:0] mdl_vec = {m_pc, m_a, m_b, m_rs1, m_rs2, m_imm,
                            m_rd, m_we, m_opc, m_f3, m_f7, m_ill};

    function automatic bit ref_legal(input logic [31:0] ins);
        return ins[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int v;
        v = 0;
        if (!ref_legal(ins)) return 32'h0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: v = $signed(ins) >>> 20;
            7'h23: v = (($signed(ins) >>> 25) * 32) + int'(ins[11:7]);
            7'h63: v = (ins[31] ? -4096 : 0) + (ins[7] ? 2048 : 0)
                       + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            7'h37, 7'h17: v = ins & 32'hFFFFF000;
            7'h6F: v = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096
                       + (ins[20] ? 2048 : 0) + int'(ins[30:21]) * 2;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic bit ref_we(input logic [31:0] ins);
        return (ins[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33})
               && ins[11:7] != 5'd0;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        {m_pc, m_a, m_b, m_rs1, m_rs2, m_imm, m_rd, m_we, m_opc, m_f3, m_f7, m_ill} = '0;
    endtask

    // Applies the stage's transfer rules to the inputs present just before the edge.
    task automatic model_edge();
        bit acc, stall;
        acc   = in_valid && (!m_valid || out_ready) && !flush;
        stall = m_valid && !out_ready;
        if (acc) begin
            m_pc  = in_pc;
            m_rs1 = in_instr[19:15];
            m_rs2 = in_instr[24:20];
            m_a   = (wb_en && wb_rd == m_rs1 && m_rs1 != 0) ? wb_data : rf_op_a;
            m_b   = (wb_en && wb_rd == m_rs2 && m_rs2 != 0) ? wb_data : rf_op_b;
            m_imm = ref_imm(in_instr);
            m_rd  = in_instr[11:7];
            m_we  = ref_we(in_instr);
            m_opc = in_instr[6:0];
            m_f3  = in_instr[14:12];
            m_f7  = in_instr[30];
            m_ill = !ref_legal(in_instr);
        end else if (stall) begin
            if (wb_en && wb_rd == m_rs1 && m_rs1 != 0) m_a = wb_data;
            if (wb_en && wb_rd == m_rs2 && m_rs2 != 0) m_b = wb_data;
        end
        m_valid = flush ? 0 : (acc || stall);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // Offers an instruction; the operands mimic a register file where x0 reads 0.
    task automatic offer(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        rf_op_a  = (ins[19:15] == 0) ? 32'h0 : a;
        rf_op_b  = (ins[24:20] == 0) ? 32'h0 : b;
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; in_valid = 0; out_ready = 0; wb_en = 0; wb_rd = 0;
        wb_data = 0; in_instr = 0; in_pc = 0; rf_op_a = 0; rf_op_b = 0;
        model_reset();
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL por_valid got=%0h exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL por_in_ready got=%0h exp=1", in_ready); end
        total++; if (dut_vec !== '0) begin bad++; $display("FAIL por_data got=%0h exp=0", dut_vec); end
        rst = 0;
    endtask

    task automatic test_addi();
        out_ready = 1;
        offer(ADDI, 32'h1000, 32'h10, 32'h99);
        cycle();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%0h exp=1", out_valid); end
        total++; if (out_op_a !== 32'h10) begin bad++; $display("FAIL addi_op_a got=%0h exp=10", out_op_a); end
        total++; if (out_imm !== 32'hFFFFFFFF) begin bad++; $display("FAIL addi_imm got=%0h exp=ffffffff", out_imm); end
        total++; if ({out_rd, out_rd_we, out_illegal} !== {5'd5, 1'b1, 1'b0})
            begin bad++; $display("FAIL addi_rd got=%0d/%0b/%0b exp=5/1/0", out_rd, out_rd_we, out_illegal); end
        total++; if (out_pc !== 32'h1000) begin bad++; $display("FAIL addi_pc got=%0h exp=1000", out_pc); end
    endtask

    task automatic test_bypass();
        out_ready = 1;
        offer(ADDI, 32'h1004, 32'h10, 32'h0);
        wb_en = 1; wb_rd = 1; wb_data = 32'hAA;
        cycle();
        total++; if (out_op_a !== 32'hAA) begin bad++; $display("FAIL byp_hit got=%0h exp=aa", out_op_a); end
        wb_rd = 0;
        cycle();
        total++; if (out_op_a !== 32'h10) begin bad++; $display("FAIL byp_x0 got=%0h exp=10", out_op_a); end
        // rd == rs1 == rs2: ADD x7,x7,x7
        offer(32'h007383B3, 32'h1008, 32'h1, 32'h2);
        wb_rd = 7; wb_data = 32'hBEEF;
        cycle();
        total++; if ({out_op_a, out_op_b} !== {32'hBEEF, 32'hBEEF})
            begin bad++; $display("FAIL byp_both got=%0h/%0h exp=beef/beef", out_op_a, out_op_b); end
        wb_en = 0;
    endtask

    task automatic test_stall_refresh();
        out_ready = 1;
        offer(ADDI, 32'h40, 32'h10, 32'h0);
        cycle();
        out_ready = 0;
        offer(SW, 32'h44, 32'h33, 32'h22);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%0h exp=0", in_ready); end
        cycle();
        total++; if ({out_valid, out_pc, out_op_a} !== {1'b1, 32'h40, 32'h10})
            begin bad++; $display("FAIL stall_hold got=%0h/%0h/%0h exp=1/40/10", out_valid, out_pc, out_op_a); end
        wb_en = 1; wb_rd = 1; wb_data = 32'h55;
        cycle();
        wb_en = 0;
        total++; if (out_op_a !== 32'h55) begin bad++; $display("FAIL stall_refresh got=%0h exp=55", out_op_a); end
        cycle();
        total++; if ({out_valid, out_pc, out_op_a, out_imm} !== {1'b1, 32'h40, 32'h55, 32'hFFFFFFFF})
            begin bad++; $display("FAIL stall_stable got=%0h/%0h/%0h/%0h exp=1/40/55/ffffffff", out_valid, out_pc, out_op_a, out_imm); end
        out_ready = 1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%0h exp=1", in_ready); end
        cycle();
        total++; if ({out_valid, out_pc, out_imm, out_rd_we, out_op_a} !== {1'b1, 32'h44, 32'h8, 1'b0, 32'h33})
            begin bad++; $display("FAIL release_next got=%0h/%0h/%0h/%0h/%0h exp=1/44/8/0/33", out_valid, out_pc, out_imm, out_rd_we, out_op_a); end
    endtask

    task automatic test_flush();
        out_ready = 1;
        offer(JAL, 32'h80, 32'h0, 32'h0);
        flush = 1;
        cycle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_accept got=%0h exp=0", out_valid); end
        flush = 0; in_valid = 0;
        cycle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%0h exp=0", out_valid); end
        offer(ADDI, 32'h84, 32'h1, 32'h0);
        cycle();
        out_ready = 0; in_valid = 0; flush = 1;
        cycle();
        flush = 0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_held got=%0h exp=0", out_valid); end
    endtask

    task automatic test_formats();
        logic [31:0] ins [3];
        logic [31:0] imm [3];
        logic [1:0]  flags [3];
        ins[0] = SW;    imm[0] = 32'h8;        flags[0] = 2'b00;
        ins[1] = JAL;   imm[1] = 32'hFFFFFFFC; flags[1] = 2'b10;
        ins[2] = 32'h0; imm[2] = 32'h0;        flags[2] = 2'b01;
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            offer(ins[i], 32'h200 + 32'(i * 4), 32'h5, 32'h6);
            cycle();
            total++; if ({out_valid, out_imm, out_rd_we, out_illegal} !== {1'b1, imm[i], flags[i]})
                begin bad++; $display("FAIL fmt_%0d got=%0h/%0h/%0b/%0b exp=1/%0h/%0b/%0b", i, out_valid, out_imm, out_rd_we, out_illegal, imm[i], flags[i][1], flags[i][0]); end
        end
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1;
        offer(SW, 32'h300, 32'h1, 32'h2);
        cycle();
        out_ready = 0;
        offer(JAL, 32'h304, 32'h0, 32'h0);
        cycle();
        #3 rst = 1;
        #1;
        total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL rst_stall_ctrl got=%0b%0b exp=01", out_valid, in_ready); end
        total++; if (dut_vec !== '0) begin bad++; $display("FAIL rst_stall_data got=%0h exp=0", dut_vec); end
        model_reset();
        #2 rst = 0;
        offer(ADDI, 32'h400, 32'h10, 32'h0);
        cycle();
        total++; if ({out_valid, out_pc, out_op_a} !== {1'b1, 32'h400, 32'h10})
            begin bad++; $display("FAIL rst_first_accept got=%0h/%0h/%0h exp=1/400/10", out_valid, out_pc, out_op_a); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            case ($urandom_range(0, 12))
                0: ins[6:0] = 7'h37;  1: ins[6:0] = 7'h17;  2: ins[6:0] = 7'h6F;
                3: ins[6:0] = 7'h67;  4: ins[6:0] = 7'h63;  5: ins[6:0] = 7'h03;
                6: ins[6:0] = 7'h23;  7: ins[6:0] = 7'h13;  8: ins[6:0] = 7'h33;
                9: ins[6:0] = 7'h0F; 10: ins[6:0] = 7'h73;
                default: ;
            endcase
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            offer(ins, $urandom, $urandom, $urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            wb_en     = 1'($urandom_range(0, 1));
            wb_rd     = 5'($urandom_range(0, 3));
            wb_data   = $urandom;
            #1;
            total++; if ({in_ready, rf_rs1, rf_rs2} !== {(!m_valid || out_ready), ins[19:15], ins[24:20]})
                begin bad++; $display("FAIL rand_in n=%0d got=%0b/%0d/%0d exp=%0b/%0d/%0d", n, in_ready, rf_rs1, rf_rs2, (!m_valid || out_ready), ins[19:15], ins[24:20]); end
            cycle();
            total++; if (out_valid !== m_valid) begin bad++; $display("FAIL rand_valid n=%0d got=%0b exp=%0b", n, out_valid, m_valid); end
            if (m_valid) begin
                total++; if (dut_vec !== mdl_vec) begin bad++; $display("FAIL rand_data n=%0d got=%0h exp=%0h", n, dut_vec, mdl_vec); end
            end
        end
        flush = 0; in_valid = 0; wb_en = 0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_bypass();
        test_stall_refresh();
        test_flush();
        test_formats();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
